// File: rtl/peak_tracker.sv
// Windowed peak detector: tracks the largest accepted sample over WINDOW samples and reports it.
// Optional minimum tracking is enabled by defining PEAK_TRACKER_MIN_EN.
module peak_tracker #(
  parameter int WIDTH  = 2,
  parameter int WINDOW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] max_out,
  output logic             new_max,
  output logic [7:0]       sample_cnt,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_max
`ifdef PEAK_TRACKER_MIN_EN
  ,
  output logic [WIDTH-1:0] min_out,
  output logic             new_min,
  output logic [WIDTH-1:0] result_min
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0]       WIN   = 8'(WINDOW);
  localparam logic [WIDTH-1:0] ZEROS = {WIDTH{1'b0}};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] w_max_nxt;
  logic [WIDTH-1:0] r_result_max;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             r_new_max;
  logic             w_new_max;
  logic             r_result_valid;
  logic             w_take;
  logic             w_enter_done;

`ifdef PEAK_TRACKER_MIN_EN
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] w_min_nxt;
  logic             r_new_min;
  logic             w_new_min;
  logic [WIDTH-1:0] r_result_min;
`endif

  assign w_take       = in_valid & r_in_ready;
  assign w_enter_done = (w_state_nxt == S_DONE);

  // Next-state and datapath update; clear overrides everything except the pulse already in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_max_nxt   = r_max;
    w_cnt_nxt   = r_cnt;
    w_new_max   = 1'b0;
`ifdef PEAK_TRACKER_MIN_EN
    w_min_nxt   = r_min;
    w_new_min   = 1'b0;
`endif
    if (clear) begin
      w_state_nxt = S_EMPTY;
      w_max_nxt   = ZEROS;
      w_cnt_nxt   = 8'd0;
`ifdef PEAK_TRACKER_MIN_EN
      w_min_nxt   = ONES;
`endif
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_take) begin
            w_max_nxt   = in_data;
            w_cnt_nxt   = 8'd1;
            w_new_max   = 1'b1;
`ifdef PEAK_TRACKER_MIN_EN
            w_min_nxt   = in_data;
            w_new_min   = 1'b1;
`endif
            w_state_nxt = (WIN == 8'd1) ? S_DONE : S_TRACK;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TRACK: begin
          if (w_take) begin
            w_cnt_nxt = r_cnt + 8'd1;
            if (in_data > r_max) begin
              w_max_nxt = in_data;
              w_new_max = 1'b1;
            end else begin
              w_max_nxt = r_max;
            end
`ifdef PEAK_TRACKER_MIN_EN
            if (in_data < r_min) begin
              w_min_nxt = in_data;
              w_new_min = 1'b1;
            end else begin
              w_min_nxt = r_min;
            end
`endif
            w_state_nxt = ((r_cnt + 8'd1) == WIN) ? S_DONE : S_TRACK;
          end else begin
            w_state_nxt = S_TRACK;
          end
        end
        S_DONE: begin
          w_state_nxt = S_EMPTY;
          w_max_nxt   = ZEROS;
          w_cnt_nxt   = 8'd0;
`ifdef PEAK_TRACKER_MIN_EN
          w_min_nxt   = ONES;
`endif
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_max_nxt   = ZEROS;
          w_cnt_nxt   = 8'd0;
`ifdef PEAK_TRACKER_MIN_EN
          w_min_nxt   = ONES;
`endif
        end
      endcase
    end
  end

  // State and max registers; the result is captured on entry to DONE so it is valid with result_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_EMPTY;
      r_in_ready     <= 1'b1;
      r_max          <= ZEROS;
      r_cnt          <= 8'd0;
      r_new_max      <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_max   <= ZEROS;
    end else begin
      r_state        <= w_state_nxt;
      r_in_ready     <= ~w_enter_done;
      r_max          <= w_max_nxt;
      r_cnt          <= w_cnt_nxt;
      r_new_max      <= w_new_max;
      r_result_valid <= w_enter_done;
      if (w_enter_done) begin
        r_result_max <= w_max_nxt;
      end
    end
  end

`ifdef PEAK_TRACKER_MIN_EN
  // Minimum tracking mirrors the max path, idling at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min        <= ONES;
      r_new_min    <= 1'b0;
      r_result_min <= ZEROS;
    end else begin
      r_min     <= w_min_nxt;
      r_new_min <= w_new_min;
      if (w_enter_done) begin
        r_result_min <= w_min_nxt;
      end
    end
  end

  assign min_out    = r_min;
  assign new_min    = r_new_min;
  assign result_min = r_result_min;
`endif

  assign in_ready     = r_in_ready;
  assign max_out      = r_max;
  assign new_max      = r_new_max;
  assign sample_cnt   = r_cnt;
  assign result_valid = r_result_valid;
  assign result_max   = r_result_max;

endmodule

// File: doc/peak_tracker.md
PEAK_TRACKER -- requirements
Module: peak_tracker

Interface
REQ-001 Parameter WIDTH, default 2, is the sample width in bits and matches the 2-bit greater-than comparator operand width.
REQ-002 Parameter WINDOW, default 4, is the number of samples per measurement window (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous abort of the current window.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_data  input  WIDTH  unsigned sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 max_out  output  WIDTH  largest sample accepted in the current window.
REQ-010 new_max  output  1  one-cycle pulse: the sample accepted last cycle was strictly greater than the stored maximum.
REQ-011 sample_cnt  output  8  samples accepted in the current window.
REQ-012 result_valid  output  1  one-cycle pulse: window complete, max_out final.
REQ-013 result_max  output  WIDTH  registered window maximum, held until the next result_valid.

Function
REQ-014 A sample is accepted only on a cycle where in_valid and in_ready are both 1.
REQ-015 FSM states: EMPTY (no sample yet), TRACK (at least one sample), DONE (one cycle, window closed).
REQ-016 EMPTY: in_ready=1; on accept, max_out<=in_data, sample_cnt<=1, new_max<=1, next TRACK (or DONE if WINDOW=1).
REQ-017 TRACK: in_ready=1; on accept, sample_cnt increments and max_out<=in_data only when in_data > max_out (unsigned, strict).
REQ-018 Equal samples do not update max_out and do not pulse new_max.
REQ-019 TRACK -> DONE on the accept that makes sample_cnt equal WINDOW.
REQ-020 DONE: in_ready=0; result_valid=1; result_max<=max_out; next EMPTY with sample_cnt<=0 and max_out<=0.
REQ-021 Latency: result_valid asserts exactly one cycle after the WINDOW-th accept.
REQ-022 in_valid while in_ready=0 is ignored; the source holds data (no drop, no capture).
REQ-023 clear=1 forces EMPTY next cycle, sample_cnt<=0, max_out<=0, no result_valid; a sample presented the same cycle is discarded; result_max unchanged.
REQ-024 clear in DONE takes priority: result_valid still pulses that cycle, next state EMPTY.
REQ-025 new_max and result_valid are registered pulses, high for exactly one cycle.

Reset
REQ-026 rst=1 immediately forces state EMPTY, max_out=0, result_max=0, sample_cnt=0, new_max=0, result_valid=0, in_ready=1 after release.
REQ-027 rst asserted mid-window discards the partial window; no result_valid is produced for it.

Configuration
REQ-028 Macro PEAK_TRACKER_MIN_EN adds outputs min_out[WIDTH], new_min (1), result_min[WIDTH], tracked symmetrically (strict less-than, first sample loads, result_min registered in DONE).
REQ-029 With PEAK_TRACKER_MIN_EN defined: min_out resets to all ones; clear and DONE reload all ones.
REQ-030 Without PEAK_TRACKER_MIN_EN: those ports and logic do not exist, and all other behaviour is identical.

Verification
REQ-031 Basic window: WIDTH=2, WINDOW=4, samples 1,3,2,0 -> new_max pulses after 1 and 3, then result_valid with result_max=3 one cycle after the 4th accept.
REQ-032 Ties: samples 2,2,2,2 -> exactly one new_max pulse, result_max=2.
REQ-033 Backpressure: in_valid held high continuously -> in_ready low for 1 cycle per window, and back-to-back windows 0,1,2,3 / 3,0,0,0 give result_max 3 then 3 with sample_cnt correct.
REQ-034 Clear: clear after 2 samples (3,1), then 0,1,1,0 -> result_max=1 and no result for the aborted window.
REQ-035 Async reset: rst pulse between clock edges after 3 samples -> outputs zero without a clock edge, and no result_valid follows.
REQ-036 With PEAK_TRACKER_MIN_EN: samples 2,0,3,1 -> result_max=3, result_min=0, new_min pulses after 2 and 0.
